// File: rtl/pattern_cfg_master_if.sv
// avalon_mm_if
// Avalon-MM bus bundle shared by the configuration master and register slaves.
//   address / write / writedata / read : driven by the master
//   waitrequest / readdata / readdatavalid : driven by the slave
// Parameters: ADDR_WIDTH (word address bits), DATA_WIDTH (data word bits).
interface avalon_mm_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  read;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/pattern_cfg_master.sv
// pattern_cfg_master
// Programs the pattern/enable control register block over Avalon-MM:
// disable matching (addr 0 <= 0), write pattern words to addr 1..PAT_WIDTH,
// optionally read them back and compare, then write the enable bit to addr 0.
// Ports:
//   clk_i, rst_n_i  : clock, asynchronous active-low reset
//   amm_master_if   : Avalon-MM master side (avalon_mm_if.master)
//   start_i         : one-cycle start request, honoured only when idle
//   pattern_i       : pattern, word k = pattern_i[REG_WIDTH*(k-1) +: REG_WIDTH]
//   enable_i        : value for control bit 0 in the final write
//   busy_o          : sequence in progress
//   done_o          : one-cycle pulse after a successful sequence
//   error_o         : readback mismatch or read timeout, sticky until next start
module pattern_cfg_master #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 4,
    parameter int PAT_WIDTH = REG_DEPTH - 1,
    parameter int PAT_SIZE  = PAT_WIDTH * REG_WIDTH,
    parameter bit VERIFY    = 1'b1,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    avalon_mm_if.master         amm_master_if,
    input  logic                start_i,
    input  logic [0:PAT_SIZE-1] pattern_i,
    input  logic                enable_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);
    localparam int ADDR_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(PAT_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIS,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_EN
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic [ADDR_W-1:0]    word_reg, word_next, word_inc;
    logic [REG_WIDTH-1:0] wdata_reg, wdata_next;
    logic                 write_reg, write_next;
    logic                 read_reg, read_next;
    logic                 done_reg, done_next;
    logic                 error_reg, error_next;
    logic [TMR_W-1:0]     timer_reg, timer_next;
    logic [0:PAT_SIZE-1]  pattern_reg;
    logic                 en_reg;
    logic                 latch;
    logic                 rd_resp;
    logic                 rd_fail;
    logic                 rd_match;
    logic                 wait_req;
    logic [REG_WIDTH-1:0] en_word;
    logic [REG_WIDTH-1:0] words [1:PAT_WIDTH];

    // Latched pattern viewed as individual register words, index = address
    for (genvar gi = 1; gi <= PAT_WIDTH; gi++) begin : g_word
        assign words[gi] = pattern_reg[REG_WIDTH*(gi-1) +: REG_WIDTH];
    end

    assign wait_req = amm_master_if.waitrequest;
    assign word_inc = word_reg + ADDR_W'(1);
    assign en_word  = {{(REG_WIDTH-1){1'b0}}, en_reg};
    assign rd_match = (amm_master_if.readdata == words[word_reg]);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        word_next  = word_reg;
        wdata_next = wdata_reg;
        write_next = write_reg;
        read_next  = read_reg;
        timer_next = timer_reg;
        error_next = error_reg;
        done_next  = 1'b0;
        latch      = 1'b0;
        rd_resp    = 1'b0;
        rd_fail    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    latch      = 1'b1;
                    error_next = 1'b0;
                    state_next = ST_DIS;
                    addr_next  = '0;
                    wdata_next = '0;
                    write_next = 1'b1;
                end
            end
            ST_DIS: begin
                if (!wait_req) begin
                    state_next = ST_WR;
                    word_next  = ADDR_W'(1);
                    addr_next  = ADDR_W'(1);
                    wdata_next = words[1];
                end
            end
            ST_WR: begin
                if (!wait_req) begin
                    if (word_reg == LAST_WORD) begin
                        word_next = ADDR_W'(1);
                        if (VERIFY) begin
                            state_next = ST_RD;
                            write_next = 1'b0;
                            read_next  = 1'b1;
                            addr_next  = ADDR_W'(1);
                        end else begin
                            state_next = ST_EN;
                            addr_next  = '0;
                            wdata_next = en_word;
                        end
                    end else begin
                        word_next  = word_inc;
                        addr_next  = word_inc;
                        wdata_next = words[word_inc];
                    end
                end
            end
            ST_RD: begin
                if (!wait_req) begin
                    // Same-cycle readdatavalid is consumed here without a wait state
                    if (amm_master_if.readdatavalid) begin
                        rd_resp = 1'b1;
                    end else begin
                        state_next = ST_RD_WAIT;
                        read_next  = 1'b0;
                        timer_next = TMR_W'(1);
                    end
                end
            end
            ST_RD_WAIT: begin
                // timer_reg counts cycles since acceptance; error shows TIMEOUT cycles after it
                if (amm_master_if.readdatavalid) begin
                    rd_resp = 1'b1;
                end else if (timer_reg >= TMR_W'(TIMEOUT - 1)) begin
                    rd_fail = 1'b1;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_EN: begin
                if (!wait_req) begin
                    state_next = ST_IDLE;
                    write_next = 1'b0;
                    addr_next  = '0;
                    wdata_next = '0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (rd_resp && !rd_match) begin
            rd_fail = 1'b1;
        end

        if (rd_fail) begin
            // Abort leaves matching disabled: no enable write, no done pulse
            state_next = ST_IDLE;
            read_next  = 1'b0;
            write_next = 1'b0;
            addr_next  = '0;
            wdata_next = '0;
            error_next = 1'b1;
        end else if (rd_resp) begin
            if (word_reg == LAST_WORD) begin
                state_next = ST_EN;
                read_next  = 1'b0;
                write_next = 1'b1;
                addr_next  = '0;
                wdata_next = en_word;
            end else begin
                state_next = ST_RD;
                read_next  = 1'b1;
                word_next  = word_inc;
                addr_next  = word_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            word_reg    <= '0;
            wdata_reg   <= '0;
            write_reg   <= 1'b0;
            read_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            timer_reg   <= '0;
            pattern_reg <= '0;
            en_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            word_reg  <= word_next;
            wdata_reg <= wdata_next;
            write_reg <= write_next;
            read_reg  <= read_next;
            done_reg  <= done_next;
            error_reg <= error_next;
            timer_reg <= timer_next;
            if (latch) begin
                pattern_reg <= pattern_i;
                en_reg      <= enable_i;
            end
        end
    end

    assign amm_master_if.address   = addr_reg;
    assign amm_master_if.write     = write_reg;
    assign amm_master_if.writedata = wdata_reg;
    assign amm_master_if.read      = read_reg;

    assign busy_o  = (state_reg != ST_IDLE);
    assign done_o  = done_reg;
    assign error_o = error_reg;
endmodule

// File: tb/tb_pattern_cfg_master.sv
// Bench for pattern_cfg_master: behavioural Avalon slave with configurable
// wait states, read latency, readback corruption and withheld readdatavalid;
// expected transaction list and completion cycle derived from the sequence rules.
module tb_pattern_cfg_master;
    localparam int RW = 32;
    localparam int RD = 4;
    localparam int PS = (RD - 1) * RW;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          enable_i = 1'b0;
    logic [0:PS-1] pattern_i = '0;
    logic          busy_o, done_o, error_o;

    avalon_mm_if #(.ADDR_WIDTH(2), .DATA_WIDTH(RW)) amm ();

    pattern_cfg_master #(
        .REG_WIDTH (RW),
        .REG_DEPTH (RD),
        .VERIFY    (1'b1),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .amm_master_if (amm),
        .start_i       (start_i),
        .pattern_i     (pattern_i),
        .enable_i      (enable_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input bit wr, input int a, input logic [31:0] d);
        return {wr, 31'(a), d};
    endfunction

    // Slave configuration and observations
    int          cfg_wait = 0, cfg_lat = 0, cfg_corrupt = 0;
    bit          cfg_hold = 0;
    logic [31:0] mem [0:3];
    logic [63:0] log_q[$];
    logic [63:0] exp_q[$];
    int          done_cyc, err_cyc, acc_rd_cyc, busy_cyc;
    int          viol_db = 0, viol_stable = 0;
    int          wcnt = 0, rd_cnt = 0;
    logic [31:0] rd_val;
    bit          prev_wait = 0, prev_err = 0;
    logic        prev_w, prev_r;
    logic [1:0]  prev_a;
    logic [31:0] prev_d;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            wcnt = 0; rd_cnt = 0; prev_wait = 0; prev_err = 0;
            amm.waitrequest = 1'b0; amm.readdatavalid = 1'b0; amm.readdata = '0;
        end else begin
            if (prev_wait && (amm.write !== prev_w || amm.read !== prev_r ||
                              amm.address !== prev_a || amm.writedata !== prev_d))
                viol_stable++;
            amm.readdatavalid = 1'b0;
            amm.readdata = '0;
            amm.waitrequest = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    amm.readdatavalid = 1'b1;
                    amm.readdata = rd_val;
                end
            end
            if (amm.write || amm.read) begin
                if (wcnt < cfg_wait) begin
                    amm.waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (amm.write) begin
                        mem[amm.address] = amm.writedata;
                        log_q.push_back(mk(1'b1, int'(amm.address), amm.writedata));
                        $display("[%0d] bus WR addr=%0d data=%h", cyc, amm.address, amm.writedata);
                    end else begin
                        log_q.push_back(mk(1'b0, int'(amm.address), 32'h0));
                        if (acc_rd_cyc < 0) acc_rd_cyc = cyc;
                        rd_val = mem[amm.address] ^ ((int'(amm.address) == cfg_corrupt) ? 32'h0000_0100 : 32'h0);
                        $display("[%0d] bus RD addr=%0d", cyc, amm.address);
                        if (!cfg_hold) begin
                            if (cfg_lat == 0) begin
                                amm.readdatavalid = 1'b1;
                                amm.readdata = rd_val;
                            end else begin
                                rd_cnt = cfg_lat;
                            end
                        end
                    end
                end
            end
            prev_wait = amm.waitrequest && (amm.write || amm.read);
            prev_w = amm.write; prev_r = amm.read; prev_a = amm.address; prev_d = amm.writedata;
            if (done_o && busy_o) viol_db++;
            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (busy_o && busy_cyc < 0) busy_cyc = cyc;
            if (error_o && !prev_err && err_cyc < 0) err_cyc = cyc;
            prev_err = error_o;
        end
    end

    task automatic clear_mon();
        log_q.delete();
        exp_q.delete();
        done_cyc = -1; err_cyc = -1; acc_rd_cyc = -1; busy_cyc = -1;
        viol_db = 0; viol_stable = 0;
    endtask

    // Expected bus transactions: disable, pattern writes, readback until the
    // first failing read, and the enable write only if every read succeeded.
    task automatic build_exp(input logic [31:0] w1, w2, w3, input bit en, input int corrupt, input bit hold);
        logic [31:0] wv [1:3];
        bit ok = 1;
        wv[1] = w1; wv[2] = w2; wv[3] = w3;
        exp_q.push_back(mk(1'b1, 0, 32'h0));
        for (int k = 1; k <= 3; k++) exp_q.push_back(mk(1'b1, k, wv[k]));
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(mk(1'b0, k, 32'h0));
            if (hold || corrupt == k) begin
                ok = 0;
                break;
            end
        end
        if (ok) exp_q.push_back(mk(1'b1, 0, {31'h0, en}));
    endtask

    task automatic kick(input logic [31:0] w1, w2, w3, input bit en, output int s);
        @(posedge clk_i); #1;
        pattern_i = {w1, w2, w3};
        enable_i = en;
        start_i = 1'b1;
        s = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        pattern_i = {$urandom, $urandom, $urandom};
        enable_i = ~en;
    endtask

    task automatic run(input string name, input logic [31:0] w1, w2, w3, input bit en,
                       input int w, input int l, input int corrupt, input bit hold, input bit restart);
        int s;
        int n;
        logic [31:0] wv [1:3];
        wv[1] = w1; wv[2] = w2; wv[3] = w3;
        cfg_wait = w; cfg_lat = l; cfg_corrupt = corrupt; cfg_hold = hold;
        clear_mon();
        mem[0] = 32'hFFFF_FFFF;
        build_exp(w1, w2, w3, en, corrupt, hold);
        kick(w1, w2, w3, en, s);
        check_eq({name, "/err_clear"}, 64'(error_o), 64'd0);
        if (restart) begin
            repeat (2) @(posedge clk_i);
            #1;
            start_i = 1'b1;
            pattern_i = {$urandom, $urandom, $urandom};
            enable_i = ~en;
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i); #1;
            if (done_cyc >= 0 || err_cyc >= 0) break;
        end
        check_eq({name, "/end_seen"}, 64'(done_cyc >= 0 || err_cyc >= 0), 64'd1);
        repeat (5) @(posedge clk_i);
        #1;
        check_eq({name, "/xfer_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s/xfer%0d", name, i), log_q[i], exp_q[i]);
        check_eq({name, "/busy_start"}, 64'(busy_cyc), 64'(s + 1));
        if (corrupt == 0 && !hold) begin
            check_eq({name, "/done_cycle"}, 64'(done_cyc - s), 64'(1 + 5 * (1 + w) + 3 * (1 + w + l)));
            check_eq({name, "/error"}, 64'(error_o), 64'd0);
            check_eq({name, "/ctrl_reg"}, 64'(mem[0]), 64'({31'h0, en}));
        end else begin
            check_eq({name, "/no_done"}, 64'(done_cyc), 64'(-1));
            check_eq({name, "/error"}, 64'(error_o), 64'd1);
            check_eq({name, "/ctrl_reg"}, 64'(mem[0]), 64'd0);
            if (hold)
                check_eq({name, "/timeout_cyc"}, 64'(err_cyc - acc_rd_cyc), 64'(TO));
        end
        for (int k = 1; k <= 3; k++)
            check_eq($sformatf("%s/reg%0d", name, k), 64'(mem[k]), 64'(wv[k]));
        check_eq({name, "/busy_done_excl"}, 64'(viol_db), 64'd0);
        check_eq({name, "/stable_in_wait"}, 64'(viol_stable), 64'd0);
        $display("run %s: start=%0d done=%0d err=%0d xfers=%0d", name, s, done_cyc, err_cyc, log_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        bit hit;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        clear_mon();
        #23 rst_n_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst/busy", 64'(busy_o), 64'd0);
        check_eq("rst/done", 64'(done_o), 64'd0);
        check_eq("rst/error", 64'(error_o), 64'd0);
        check_eq("rst/write", 64'(amm.write), 64'd0);
        check_eq("rst/read", 64'(amm.read), 64'd0);
        check_eq("rst/address", 64'(amm.address), 64'd0);
        check_eq("rst/writedata", 64'(amm.writedata), 64'd0);

        run("basic", 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1, 0, 0, 0, 1'b0, 1'b0);
        run("wait3", 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1, 3, 0, 0, 1'b0, 1'b0);
        run("corrupt2", 32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003, 1'b1, 0, 1, 2, 1'b0, 1'b0);
        run("timeout", 32'h0BAD_F00D, 32'hFEED_0002, 32'h1234_5678, 1'b1, 1, 0, 0, 1'b1, 1'b0);
        run("recover", 32'hDEAD_BEEF, 32'hCAFE_0002, 32'h0000_0003, 1'b0, 0, 2, 0, 1'b0, 1'b0);
        run("restart", 32'h7777_0001, 32'h8888_0002, 32'h9999_0003, 1'b1, 0, 0, 0, 1'b0, 1'b1);

        // Reset while a pattern write is on the bus
        cfg_wait = 0; cfg_lat = 0; cfg_corrupt = 0; cfg_hold = 0;
        clear_mon();
        kick(32'h1, 32'h2, 32'h3, 1'b1, s);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (amm.write && amm.address == 2'd2) begin
                hit = 1;
                break;
            end
            @(posedge clk_i); #1;
        end
        check_eq("midrst/wr2_seen", 64'(hit), 64'd1);
        #1 rst_n_i = 1'b0;
        #1;
        check_eq("midrst/write", 64'(amm.write), 64'd0);
        check_eq("midrst/read", 64'(amm.read), 64'd0);
        check_eq("midrst/busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #3 rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        run("after_rst", 32'h4444_0001, 32'h5555_0002, 32'h6666_0003, 1'b1, 0, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            int corrupt;
            corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run($sformatf("rand%0d", i), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), corrupt, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
